aes_stream_adapter: RTL and testbench

- Byte-stream front/back end for the AES-128 cipher core.
- Packs 16 input bytes into a 128-bit block and pulses the cipher start.
- Waits for the cipher's done pulse, captures the 128-bit result, and serialises it as 16 output bytes.
- Sits between the byte-wide link interface and the cipher: directly upstream of the cipher input, directly downstream of its output.

---
 rtl/aes_stream_adapter.sv | 124 ++++++++++++
 tb/tb_aes_stream_adapter.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_stream_adapter.sv
// Byte-stream adapter around the AES-128 core: packs 16 bytes into a block, starts
// the cipher, waits for its done pulse and serialises the result back out as bytes.
module aes_stream_adapter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic [7:0]   s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [127:0] blk_in,
    output logic         blk_start,
    input  logic [127:0] blk_out,
    input  logic         blk_done,
    output logic [7:0]   m_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         busy,
    output logic         err_timeout,
    input  logic         clr_err
);

    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]   state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] blk_in_q, blk_in_d;
    logic [127:0] outbuf_q, outbuf_d;
    logic [7:0]   timer_q, timer_d;
    logic         blk_start_q, blk_start_d;
    logic         err_q, err_d;
    logic         tmo_hit;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        blk_in_d    = blk_in_q;
        outbuf_d    = outbuf_q;
        timer_d     = timer_q;
        blk_start_d = 1'b0;
        tmo_hit     = 1'b0;

        case (state_q)
            S_FILL: begin
                if (s_valid) begin
                    blk_in_d = {blk_in_q[119:0], s_data};
                    if (cnt_q == 4'd15) begin
                        cnt_d       = '0;
                        state_d     = S_START;
                        // registered start is high exactly while the FSM sits in START
                        blk_start_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_START: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 8'd1;
                if (blk_done) begin
                    outbuf_d = blk_out;
                    state_d  = S_DRAIN;
                end else if (timer_q == TMO_LAST) begin
                    tmo_hit = 1'b1;
                    cnt_d   = '0;
                    state_d = S_FILL;
                end
            end
            default: begin
                if (m_ready) begin
                    outbuf_d = {outbuf_q[119:0], 8'h00};
                    if (cnt_q == 4'd15) begin
                        cnt_d   = '0;
                        state_d = S_FILL;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
        endcase

        // a timeout in the same cycle as clr_err keeps the flag set
        err_d = err_q;
        if (clr_err) err_d = 1'b0;
        if (tmo_hit) err_d = 1'b1;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= S_FILL;
            cnt_q       <= '0;
            blk_in_q    <= '0;
            outbuf_q    <= '0;
            timer_q     <= '0;
            blk_start_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            blk_in_q    <= blk_in_d;
            outbuf_q    <= outbuf_d;
            timer_q     <= timer_d;
            blk_start_q <= blk_start_d;
            err_q       <= err_d;
        end
    end

    assign s_ready     = (state_q == S_FILL);
    assign busy        = (state_q != S_FILL);
    assign m_valid     = (state_q == S_DRAIN);
    assign m_data      = (state_q == S_DRAIN) ? outbuf_q[127:120] : 8'h00;
    assign blk_in      = blk_in_q;
    assign blk_start   = blk_start_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_aes_stream_adapter.sv
// Scoreboard bench for aes_stream_adapter: a behavioural cipher responder queues the
// expected output bytes, and a monitor pops them on every output handshake.
module tb_aes_stream_adapter;

    localparam int TMO = 64;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         CLK;
    logic         reset;
    logic [7:0]   s_data;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] blk_in;
    logic         blk_start;
    logic [127:0] blk_out;
    logic         blk_done;
    logic [7:0]   m_data;
    logic         m_valid;
    logic         m_ready;
    logic         busy;
    logic         err_timeout;
    logic         clr_err;

    logic         rsp_done, spur_done;
    logic [127:0] rsp_out, spur_out;
    logic [127:0] rsp_blk, rsp_exp;
    logic [7:0]   mon_exp;
    bit           rsp_hang;
    int           rsp_lat;

    int n_cmp = 0;
    int n_bad = 0;
    int start_cnt = 0;
    int rx_count = 0;

    logic [127:0] exp_blk_q[$];
    logic [7:0]   exp_byte_q[$];

    assign blk_done = rsp_done | spur_done;
    assign blk_out  = spur_done ? spur_out : rsp_out;

    aes_stream_adapter #(.TIMEOUT(TMO)) dut (
        .CLK(CLK), .reset(reset),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .blk_in(blk_in), .blk_start(blk_start), .blk_out(blk_out), .blk_done(blk_done),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .err_timeout(err_timeout), .clr_err(clr_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [127:0] cipher_model(input logic [127:0] b);
        if (b == FIPS_PT) return FIPS_CT;
        return {b[63:0], b[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    // Cipher stand-in: checks the block it is handed and answers after rsp_lat cycles.
    initial begin
        rsp_done = 1'b0;
        rsp_out  = '0;
        forever begin
            @(negedge CLK);
            if (blk_start === 1'b1 && reset === 1'b0) begin
                start_cnt++;
                n_cmp++;
                if (exp_blk_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL blk_start_unexpected: got start with blk_in=%h, required none", blk_in);
                end else begin
                    rsp_exp = exp_blk_q.pop_front();
                    if (blk_in !== rsp_exp) begin
                        n_bad++;
                        $display("FAIL blk_in: got %h, required %h", blk_in, rsp_exp);
                    end
                end
                if (!rsp_hang) begin
                    rsp_blk = cipher_model(blk_in);
                    repeat (rsp_lat) @(posedge CLK);
                    #1;
                    rsp_out  = rsp_blk;
                    rsp_done = 1'b1;
                    for (int i = 0; i < 16; i++) exp_byte_q.push_back(rsp_blk[127 - 8*i -: 8]);
                    @(posedge CLK);
                    #1;
                    rsp_done = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (m_valid === 1'b1 && m_ready === 1'b1 && reset === 1'b0) begin
                rx_count++;
                n_cmp++;
                if (exp_byte_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL m_data_unexpected: got byte %h, required no output", m_data);
                end else begin
                    mon_exp = exp_byte_q.pop_front();
                    if (m_data !== mon_exp) begin
                        n_bad++;
                        $display("FAIL m_data: got %h, required %h", m_data, mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int k;
        k = 0;
        s_valid = 1'b1;
        s_data  = b;
        @(negedge CLK);
        while (s_ready !== 1'b1 && k < 200) begin
            @(negedge CLK);
            k++;
        end
        if (k >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_byte_timeout: s_ready stayed %b, required 1", s_ready);
        end
        @(posedge CLK);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] b, input bit gaps);
        exp_blk_q.push_back(b);
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge CLK);
                    #1;
                end
            end
            send_byte(b[127 - 8*i -: 8]);
        end
    endtask

    task automatic wait_drained(input string name);
        int k;
        k = 0;
        @(negedge CLK);
        while (!(busy === 1'b0 && exp_byte_q.size() == 0 && exp_blk_q.size() == 0) && k < 2000) begin
            @(negedge CLK);
            k++;
        end
        n_cmp++;
        if (k >= 2000) begin
            n_bad++;
            $display("FAIL %s_drain: busy=%b pending_bytes=%0d, required idle with 0 pending",
                     name, busy, exp_byte_q.size());
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_rx(input int target);
        int k;
        k = 0;
        while (rx_count < target && k < 1000) begin
            @(posedge CLK);
            #1;
            k++;
        end
        if (k >= 1000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_rx: got %0d bytes, required %0d", rx_count, target);
        end
    endtask

    task automatic test_reset;
        #12;
        n_cmp++;
        if ({s_ready, busy, blk_start, m_valid, err_timeout, m_data, blk_in} !== {5'b10000, 8'h00, 128'h0}) begin
            n_bad++;
            $display("FAIL reset_values: got ready/busy/start/mvalid/err=%b%b%b%b%b m_data=%h blk_in=%h, required 10000 00 0",
                     s_ready, busy, blk_start, m_valid, err_timeout, m_data, blk_in);
        end
        @(negedge CLK);
        reset = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_basic;
        int sc, rb;
        sc = start_cnt;
        rb = rx_count;
        rsp_lat = 12;
        send_block(FIPS_PT, 1'b0);
        wait_drained("basic");
        n_cmp++;
        if (start_cnt - sc != 1 || rx_count - rb != 16) begin
            n_bad++;
            $display("FAIL basic_counts: got starts=%0d bytes=%0d, required 1 and 16", start_cnt - sc, rx_count - rb);
        end
    endtask

    task automatic test_gaps;
        logic [127:0] pt;
        int hs, cyc, bad;
        pt = 128'h3243f6a8885a308d313198a2e0370734;
        hs = 0; cyc = 0; bad = 0;
        send_block(pt, 1'b1);
        s_valid = 1'b1;
        s_data  = 8'hee;
        while (hs < 16 && cyc < 1000) begin
            @(negedge CLK);
            cyc++;
            if (s_ready !== 1'b0 || busy !== 1'b1) bad++;
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                hs++;
                if (hs == 16) s_valid = 1'b0;
            end
        end
        s_valid = 1'b0;
        n_cmp++;
        if (bad != 0 || hs != 16) begin
            n_bad++;
            $display("FAIL gaps_ready_low: got %0d cycles with s_ready high, %0d bytes, required 0 and 16", bad, hs);
        end
        wait_drained("gaps");
        n_cmp++;
        if (blk_in !== pt) begin
            n_bad++;
            $display("FAIL gaps_blk_hold: got %h, required %h", blk_in, pt);
        end
    endtask

    task automatic test_backpressure;
        int base, bad;
        base = rx_count;
        bad = 0;
        send_block(FIPS_PT, 1'b0);
        wait_rx(base + 4);
        m_ready = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            if (m_valid !== 1'b1 || m_data !== 8'h6a) begin
                bad++;
                $display("FAIL backpressure_hold: got m_valid=%b m_data=%h, required 1 6a", m_valid, m_data);
            end
        end
        n_cmp++;
        if (bad != 0) n_bad++;
        @(posedge CLK);
        #1;
        m_ready = 1'b1;
        wait_drained("backpressure");
        n_cmp++;
        if (rx_count - base != 16) begin
            n_bad++;
            $display("FAIL backpressure_count: got %0d bytes, required 16", rx_count - base);
        end
    endtask

    task automatic test_timeout;
        int k;
        bit found;
        k = 0;
        found = 1'b0;
        rsp_hang = 1'b1;
        send_block(128'hdeadbeef0123456789abcdeffedcba98, 1'b0);
        while (k < 300 && !found) begin
            @(negedge CLK);
            if (err_timeout === 1'b1) found = 1'b1;
            else k++;
        end
        n_cmp++;
        if (!found || k != TMO + 1) begin
            n_bad++;
            $display("FAIL timeout_cycle: got err after %0d cycles (found=%0b), required %0d", k, found, TMO + 1);
        end
        n_cmp++;
        if (busy !== 1'b0 || s_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_fill: got busy=%b s_ready=%b, required 0 1", busy, s_ready);
        end
        rsp_hang = 1'b0;
        @(posedge CLK);
        #1;
        send_block(128'h0102030405060708090a0b0c0d0e0f10, 1'b0);
        wait_drained("after_timeout");
        n_cmp++;
        if (err_timeout !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_sticky: got %b, required 1", err_timeout);
        end
        clr_err = 1'b1;
        @(posedge CLK);
        #1;
        clr_err = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (err_timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_err: got %b, required 0", err_timeout);
        end
        @(posedge CLK);
        #1;
        // done on the last permitted WAIT cycle
        rsp_lat = TMO;
        send_block(128'hcafef00d112233445566778899001122, 1'b0);
        wait_drained("done_at_timeout");
        n_cmp++;
        if (err_timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL done_at_timeout_err: got %b, required 0", err_timeout);
        end
        rsp_lat = 12;
    endtask

    task automatic test_reset_mid;
        int base, sc;
        logic [127:0] pt;
        pt = 128'h55aa55aa00ff00ff123456789abcdef0;
        for (int i = 0; i < 9; i++) send_byte(pt[127 - 8*i -: 8]);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({s_ready, busy, blk_start, m_valid, err_timeout, m_data, blk_in} !== {5'b10000, 8'h00, 128'h0}) begin
            n_bad++;
            $display("FAIL reset_mid_fill: got ready/busy/start/mvalid/err=%b%b%b%b%b m_data=%h blk_in=%h, required 10000 00 0",
                     s_ready, busy, blk_start, m_valid, err_timeout, m_data, blk_in);
        end
        @(negedge CLK);
        reset = 1'b0;
        @(posedge CLK);
        #1;
        base = rx_count;
        send_block(pt, 1'b0);
        wait_rx(base + 4);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({s_ready, busy, blk_start, m_valid, err_timeout, m_data, blk_in} !== {5'b10000, 8'h00, 128'h0}) begin
            n_bad++;
            $display("FAIL reset_mid_drain: got ready/busy/start/mvalid/err=%b%b%b%b%b m_data=%h blk_in=%h, required 10000 00 0",
                     s_ready, busy, blk_start, m_valid, err_timeout, m_data, blk_in);
        end
        exp_byte_q.delete();
        @(negedge CLK);
        reset = 1'b0;
        @(posedge CLK);
        #1;
        sc = start_cnt;
        base = rx_count;
        send_block(FIPS_PT, 1'b0);
        wait_drained("after_reset");
        n_cmp++;
        if (start_cnt - sc != 1 || rx_count - base != 16) begin
            n_bad++;
            $display("FAIL after_reset_counts: got starts=%0d bytes=%0d, required 1 and 16", start_cnt - sc, rx_count - base);
        end
    endtask

    task automatic test_spurious;
        logic [127:0] pt;
        logic [7:0] held;
        int base;
        pt = 128'h0badc0de0badc0de0badc0de0badc0de;
        exp_blk_q.push_back(pt);
        for (int i = 0; i < 5; i++) send_byte(pt[127 - 8*i -: 8]);
        spur_out  = {$urandom, $urandom, $urandom, $urandom};
        spur_done = 1'b1;
        @(posedge CLK);
        #1;
        spur_done = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (busy !== 1'b0 || s_ready !== 1'b1 || m_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL spurious_fill: got busy=%b s_ready=%b m_valid=%b, required 0 1 0", busy, s_ready, m_valid);
        end
        @(posedge CLK);
        #1;
        base = rx_count;
        for (int i = 5; i < 16; i++) send_byte(pt[127 - 8*i -: 8]);
        wait_rx(base + 2);
        m_ready = 1'b0;
        held = exp_byte_q.size() > 0 ? exp_byte_q[0] : 8'h00;
        spur_out  = ~cipher_model(pt);
        spur_done = 1'b1;
        @(posedge CLK);
        #1;
        spur_done = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (m_valid !== 1'b1 || busy !== 1'b1 || m_data !== held) begin
            n_bad++;
            $display("FAIL spurious_drain: got m_valid=%b busy=%b m_data=%h, required 1 1 %h", m_valid, busy, m_data, held);
        end
        @(posedge CLK);
        #1;
        m_ready = 1'b1;
        wait_drained("spurious");
        n_cmp++;
        if (rx_count - base != 16) begin
            n_bad++;
            $display("FAIL spurious_count: got %0d bytes, required 16", rx_count - base);
        end
    endtask

    initial begin
        reset     = 1'b1;
        s_valid   = 1'b0;
        s_data    = 8'h00;
        m_ready   = 1'b1;
        clr_err   = 1'b0;
        spur_done = 1'b0;
        spur_out  = '0;
        rsp_hang  = 1'b0;
        rsp_lat   = 12;

        test_reset();
        test_basic();
        test_gaps();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_spurious();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
